// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
package load_store_unit_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

endpackage

// File: rtl/lsu_load_align.sv
// Load lane selection and sign/zero extension of a returned bus word.
module lsu_load_align (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    import load_store_unit_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane, then extend according to the load type.
    always_comb begin
        w_byte = i_word[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            FUNCT3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LH:  o_data = {{16{w_half[15]}}, w_half};
            FUNCT3_LBU: o_data = {24'd0, w_byte};
            FUNCT3_LHU: o_data = {16'd0, w_half};
            default:    o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one bus transaction per access, stalling the pipe.
module load_store_unit #(
    parameter int DATA_WIDTH = load_store_unit_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  stall_o,
    output logic                  access_err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);
    import load_store_unit_pkg::*;

    lsu_state_e r_state, w_next;

    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_pending;
    logic                  w_store;
    logic                  w_f3_ok;
    logic                  w_misalign;
    logic                  w_legal;
    logic                  w_go;
    logic                  w_stall;
    logic                  w_err;
    logic                  w_req;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    // A store wins when both read and write are requested.
    assign w_pending = mem_read_i | mem_write_i;
    assign w_store   = mem_write_i;

    // Legality: funct3 must be defined for the access kind and the address naturally aligned.
    always_comb begin
        if (w_store)
            w_f3_ok = (funct3_i == FUNCT3_SB) || (funct3_i == FUNCT3_SH) ||
                      (funct3_i == FUNCT3_SW);
        else
            w_f3_ok = (funct3_i == FUNCT3_LB) || (funct3_i == FUNCT3_LH) ||
                      (funct3_i == FUNCT3_LW) || (funct3_i == FUNCT3_LBU) ||
                      (funct3_i == FUNCT3_LHU);
        w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        w_legal    = w_f3_ok && !w_misalign;
    end

    // Byte enables and lane-replicated write data from access size and address.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wr_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wr_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wr_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wr_data_i;
            end
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and control outputs.
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_err   = 1'b0;
        w_req   = 1'b0;
        w_go    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    if (w_legal) begin
                        w_go    = 1'b1;
                        w_stall = 1'b1;
                        w_next  = REQ;
                    end else begin
                        w_err   = 1'b1;
                    end
                end
            end
            REQ: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (bus_gnt_i) w_next = r_we ? DONE : WAIT_R;
            end
            WAIT_R: begin
                w_stall = 1'b1;
                if (bus_rvalid_i) w_next = DONE;
            end
            DONE: begin
                // Always drop back: the pipe advances this cycle, so the
                // still-visible request belongs to the finished instruction.
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture bus fields on acceptance; they stay put through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= 4'b0000;
            r_wdata   <= '0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
        end else if (w_go) begin
            r_we      <= w_store;
            r_addr    <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_funct3  <= funct3_i;
            r_addr_lo <= addr_i[1:0];
        end
    end

    lsu_load_align u_align (
        .i_word   (bus_rdata_i),
        .i_addr   (r_addr_lo),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // Load result updates only when read data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    r_rd_data <= '0;
        else if ((r_state == WAIT_R) && bus_rvalid_i)  r_rd_data <= w_load_data;
    end

    assign rd_data_o    = r_rd_data;
    assign stall_o      = w_stall;
    assign access_err_o = w_err;
    assign bus_req_o    = w_req;
    assign bus_we_o     = r_we;
    assign bus_addr_o   = r_addr;
    assign bus_be_o     = r_be;
    assign bus_wdata_o  = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected load results.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic        access_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int          vectors = 0;
    int          miscmp  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd = 32'h0;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wr_data_i    (wr_data_i),
        .rd_data_o    (rd_data_o),
        .stall_o      (stall_o),
        .access_err_o (access_err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // One legal access with a bus that grants after gdly REQ cycles and
    // returns read data the cycle after the grant. Entered at a falling edge.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int gdly,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rd);
        int   stalls  = 0;
        int   reqc    = 0;
        logic rv_pend = 1'b0;
        logic done    = 1'b0;
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wr_data_i   = wd;
        if (!wr) sb_q.push_back(exp_rd);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (c == 0) check({tag, " err"}, {31'd0, access_err_o}, 32'd0);
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = rv_pend;
            bus_rdata_i  = rv_pend ? rw : 32'h5A5A_5A5A;
            rv_pend      = 1'b0;
            if (bus_req_o) begin
                reqc++;
                check({tag, " addr"}, bus_addr_o, {a[31:2], 2'b00});
                check({tag, " be"},   {28'd0, bus_be_o}, {28'd0, exp_be});
                check({tag, " we"},   {31'd0, bus_we_o}, {31'd0, wr});
                if (wr) check({tag, " wdata"}, bus_wdata_o, exp_wdata);
                if (reqc > gdly) begin
                    bus_gnt_i = 1'b1;
                    rv_pend   = !wr;
                end else begin
                    // stray read-valid while waiting for a grant must be ignored
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = 32'hBAD0_BAD0;
                end
            end
            @(negedge clk);
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " stalls"}, stalls, wr ? 32'(2 + gdly) : 32'(3 + gdly));
        check({tag, " reqcyc"}, reqc, 32'(gdly + 1));
        check({tag, " req_in_done"}, {31'd0, bus_req_o}, 32'd0);
        if (!wr && sb_q.size() > 0) begin
            last_rd = sb_q.pop_front();
            check({tag, " rd_data"}, rd_data_o, last_rd);
        end
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        check({tag, " rd_hold"}, rd_data_o, last_rd);
        @(negedge clk);
    endtask

    // Illegal access: error pulse, no stall, no bus activity, result untouched.
    task automatic run_bad(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wr_data_i   = 32'h1357_9BDF;
        #1;
        check({tag, " err"},   {31'd0, access_err_o}, 32'd1);
        check({tag, " stall"}, {31'd0, stall_o}, 32'd0);
        check({tag, " req"},   {31'd0, bus_req_o}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, " req2"},  {31'd0, bus_req_o}, 32'd0);
        check({tag, " rd"},    rd_data_o, last_rd);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        #1;
        check({tag, " err_off"}, {31'd0, access_err_o}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b1;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        funct3_i     = 3'b000;
        addr_i       = 32'h0;
        wr_data_i    = 32'h0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        check("rst rd_data", rd_data_o, 32'h0);
        check("rst req",     {31'd0, bus_req_o}, 32'd0);
        check("rst stall",   {31'd0, stall_o}, 32'd0);
        check("rst addr",    bus_addr_o, 32'h0);
        check("rst be",      {28'd0, bus_be_o}, 32'h0);
        check("rst wdata",   bus_wdata_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("LW100",  1, 0, 3'b010, 32'h100, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        run_op("LB103",  1, 0, 3'b000, 32'h103, 32'hFFFF_FFFF, 32'h80FF_FFFF, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        run_op("LBU103", 1, 0, 3'b100, 32'h103, 32'hFFFF_FFFF, 32'h80FF_FFFF, 0, 4'b1000, 32'h0, 32'h0000_0080);
        run_op("LH102",  1, 0, 3'b001, 32'h102, 32'hFFFF_FFFF, 32'h8001_1234, 0, 4'b1100, 32'h0, 32'hFFFF_8001);
        run_op("LHU000", 1, 0, 3'b101, 32'h000, 32'hFFFF_FFFF, 32'h8001_F234, 0, 4'b0011, 32'h0, 32'h0000_F234);
        run_op("LB101",  1, 0, 3'b000, 32'h101, 32'hFFFF_FFFF, 32'h1122_7F44, 0, 4'b0010, 32'h0, 32'h0000_007F);
        run_op("SH102",  0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0,         0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_op("SB101",  0, 1, 3'b000, 32'h101, 32'h0000_005A, 32'h0,         0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
        run_op("SW200",  0, 1, 3'b010, 32'h200, 32'h1234_5678, 32'h0,         0, 4'b1111, 32'h1234_5678, 32'h0);
        run_op("RWSW204",1, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h0,         0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        run_op("LWgnt5", 1, 0, 3'b010, 32'h300, 32'hFFFF_FFFF, 32'h0BAD_F00D, 5, 4'b1111, 32'h0, 32'h0BAD_F00D);
        run_op("SWgnt3", 0, 1, 3'b010, 32'h304, 32'h7654_3210, 32'h0,         3, 4'b1111, 32'h7654_3210, 32'h0);

        run_bad("LW101",   1, 0, 3'b010, 32'h101);
        run_bad("LH103",   1, 0, 3'b001, 32'h103);
        run_bad("SW102",   0, 1, 3'b010, 32'h102);
        run_bad("S_f3100", 0, 1, 3'b100, 32'h100);
        run_bad("L_f3011", 1, 0, 3'b011, 32'h100);
        run_bad("L_f3110", 1, 0, 3'b110, 32'h100);

        // Reset while waiting for read data.
        mem_read_i = 1'b1;
        funct3_i   = 3'b010;
        addr_i     = 32'h100;
        wr_data_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        check("rstw req", {31'd0, bus_req_o}, 32'd1);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i  = 1'b0;
        mem_read_i = 1'b0;
        #1;
        check("rstw stall", {31'd0, stall_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw req0",   {31'd0, bus_req_o}, 32'd0);
        check("rstw rd0",    rd_data_o, 32'h0);
        check("rstw stall0", {31'd0, stall_o}, 32'd0);
        check("rstw addr0",  bus_addr_o, 32'h0);
        check("rstw be0",    {28'd0, bus_be_o}, 32'h0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1111_1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("late rv rd",    rd_data_o, 32'h0);
        check("late rv stall", {31'd0, stall_o}, 32'd0);
        bus_rvalid_i = 1'b0;
        last_rd      = 32'h0;
        @(negedge clk);

        run_op("LWpost", 1, 0, 3'b010, 32'h010, 32'hFFFF_FFFF, 32'h0000_0042, 0, 4'b1111, 32'h0, 32'h0000_0042);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath and address width; only 32 is supported.
REQ-002 clk  input  1  single clock for all state; rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_read_i  input  1  load requested by the MEM-stage instruction.
REQ-005 mem_write_i  input  1  store requested by the MEM-stage instruction.
REQ-006 funct3_i  input  3  access size and sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-007 addr_i  input  32  byte address, taken from the ALU result.
REQ-008 wr_data_i  input  32  store data, from rs2.
REQ-009 rd_data_o  output  32  load result, aligned and extended.
REQ-010 stall_o  output  1  freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB while high.
REQ-011 access_err_o  output  1  misaligned address or illegal funct3 for the current access.
REQ-012 bus_req_o  output  1  bus request.
REQ-013 bus_we_o  output  1  1 = write, 0 = read.
REQ-014 bus_addr_o  output  32  word-aligned address; bits [1:0] are 0.
REQ-015 bus_be_o  output  4  byte enables.
REQ-016 bus_wdata_o  output  32  write data, lane-replicated.
REQ-017 bus_gnt_i  input  1  request accepted in this cycle.
REQ-018 bus_rvalid_i  input  1  read data valid.
REQ-019 bus_rdata_i  input  32  read data word.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT_R and DONE.
REQ-021 IDLE, access pending (mem_read_i | mem_write_i) and legal: the block SHALL register the bus fields, go to REQ and assert stall_o combinationally.
REQ-022 When mem_read_i and mem_write_i are both high, the store SHALL take priority.
REQ-023 IDLE, access pending but illegal: the block SHALL pulse access_err_o combinationally, hold stall_o=0, issue no bus request, leave rd_data_o unchanged and stay in IDLE.
REQ-024 An access SHALL be illegal when:
- a halfword has addr[0]=1;
- a word has addr[1:0]!=0;
- a store has funct3 outside 000/001/010;
- a load has funct3 outside 000/001/010/100/101.
REQ-025 REQ: bus_req_o=1 and all bus fields SHALL stay stable until bus_gnt_i=1.
- On gnt, a store SHALL go to DONE and a load SHALL go to WAIT_R.
- bus_rvalid_i SHALL be ignored in REQ.
REQ-026 WAIT_R: on bus_rvalid_i, the block SHALL register the extracted and extended data into rd_data_o and go to DONE.
REQ-027 DONE: stall_o=0 for exactly one cycle and rd_data_o valid; the next state SHALL be IDLE unconditionally, so the same instruction is never re-issued.
REQ-028 stall_o SHALL equal 1 in REQ and WAIT_R, 1 in IDLE when a legal access is pending, and 0 otherwise.
REQ-029 Minimum latency with gnt and rvalid arriving in the earliest legal cycles:
- load stalls 3 cycles, data in the 4th;
- store stalls 2 cycles.
REQ-030 Stores SHALL drive byte enables and write data as follows:
- SB: be=0001<<addr[1:0], wdata={4{wr_data[7:0]}};
- SH: be=0011 or 1100 by addr[1], wdata={2{wr_data[15:0]}};
- SW: be=1111, wdata=wr_data.
REQ-031 For loads, bus_be_o SHALL follow the size rules of REQ-030.
REQ-032 Load results SHALL select the byte or halfword lane by addr[1:0]:
- LB/LH sign-extend;
- LBU/LHU zero-extend.
REQ-033 rd_data_o SHALL hold its last value outside WAIT_R→DONE updates.

Reset
REQ-034 An asserted rst_n SHALL immediately force:
- state=IDLE;
- rd_data_o=0;
- bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_be_o=0, bus_wdata_o=0.
REQ-035 Reset in REQ or WAIT_R SHALL abandon the transaction, and a late rvalid SHALL be ignored after reset.

Structure
REQ-036 The shared package SHALL hold lsu_state_e and FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW, alongside DATA_WIDTH.
REQ-037 The load extraction and extension logic SHALL be a combinational sub-module, lsu_load_align, with inputs word, addr[1:0] and funct3 and output data.

Verification
REQ-038 LW 0x100, gnt in the first REQ cycle, rvalid next cycle with 0xDEADBEEF -> stall 3 cycles, rd_data=0xDEADBEEF, be=1111.
REQ-039 LB 0x103, rdata=0x80FFFFFF -> rd_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH 0x102 with wr_data 0x0000ABCD -> be=1100, wdata=0xABCDABCD, bus_we=1, stall 2 cycles.
REQ-041 LW 0x101 -> access_err=1, stall=0, no bus_req.
REQ-042 gnt withheld for 5 cycles -> bus fields stable and stall held for 5 cycles.
REQ-043 rst_n asserted in WAIT_R -> immediate IDLE with bus_req=0 and rd_data=0.
